// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared func3 op encodings, FSM state encoding and iteration count for div_unit
package div_unit_pkg;
  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring iteration (shift remainder:dividend, trial-subtract divisor)
module div_step
  import div_unit_pkg::*;
#(
  parameter int XLEN = DIV_ITERS
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] dvd_n,
  output logic            q_bit
);
  logic [XLEN:0] sh, diff;
  assign sh = {rem, dvd[XLEN-1]};
  assign diff = sh - {1'b0, dvs};
  assign q_bit = ~diff[XLEN];
  assign rem_n = q_bit ? diff[XLEN-1:0] : sh[XLEN-1:0];
  assign dvd_n = {dvd[XLEN-2:0], 1'b0};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU restoring divider; define DIV_FAST_PATH_EN to finish divide-by-zero and overflow in one cycle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = DIV_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  state_t state, nxt;
  logic [XLEN-1:0] rem, dvd, dvs, rem_n, dvd_n, a_abs, b_abs, init_rem, init_dvd;
  logic [CW-1:0] cnt;
  logic sel_rem, q_neg, r_neg, sgn, a_neg, b_neg, accept, last, fast, q_bit, unused_f3;
  assign unused_f3 = func3[2];
  assign sgn = ~func3[0];
  assign a_neg = sgn & op_a[XLEN-1];
  assign b_neg = sgn & op_b[XLEN-1];
  assign a_abs = a_neg ? -op_a : op_a;
  assign b_abs = b_neg ? -op_b : op_b;
  assign accept = (state == S_IDLE || state == S_DONE) && start && !flush;
  assign last = cnt == CW'(XLEN - 1);
`ifdef DIV_FAST_PATH_EN
  logic ovf;
  assign ovf = sgn & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
  assign fast = ovf | ~|op_b;
  assign init_rem = fast ? (ovf ? '0 : a_abs) : '0;
  assign init_dvd = fast ? (ovf ? {1'b1, {(XLEN-1){1'b0}}} : '1) : a_abs;
`else
  assign fast = 1'b0;
  assign init_rem = '0;
  assign init_dvd = a_abs;
`endif
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem),
    .dvd(dvd),
    .dvs(dvs),
    .rem_n(rem_n),
    .dvd_n(dvd_n),
    .q_bit(q_bit)
  );
  always_comb
    nxt = flush ? S_IDLE :
          accept ? (fast ? S_FIX : S_BUSY) :
          state == S_BUSY ? (last ? S_FIX : S_BUSY) :
          state == S_FIX ? S_DONE :
          state == S_DONE ? S_IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      result <= '0;
    end else if (accept) begin
      sel_rem <= func3[1];
      q_neg <= (a_neg ^ b_neg) & (|op_b);
      r_neg <= a_neg;
      cnt <= '0;
      rem <= init_rem;
      dvd <= init_dvd;
      dvs <= b_abs;
    end else if (state == S_BUSY) begin
      rem <= rem_n;
      dvd <= dvd_n | XLEN'(q_bit);
      cnt <= cnt + 1'b1;
    end else if (state == S_FIX && !flush)
      result <= sel_rem ? (r_neg ? -rem : rem) : (q_neg ? -dvd : dvd);
  assign busy = state == S_BUSY || state == S_FIX;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit against an arithmetic reference model
module tb_div_unit;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0] func3 = 3'b100;
  logic [31:0] op_a = 0, op_b = 0;
  logic busy, done;
  logic [31:0] result;
  typedef struct {logic [31:0] res; time t;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  logic [31:0] last_res = 0;
  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_, sq, sr;
    logic ovf;
    sa = a;
    sb_ = b;
    sq = 0;
    sr = 0;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (b != 0 && !ovf) begin
      sq = sa / sb_;
      sr = sa % sb_;
    end
    case (f)
      3'b100: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : sq;
      3'b101: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'b110: return b == 0 ? a : ovf ? 32'h0 : sr;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int lat;
    func3 = f;
    op_a = a;
    op_b = b;
    start = 1;
    @(posedge clk);
    lat = 33;
`ifdef DIV_FAST_PATH_EN
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 1;
`endif
    if (push) begin
      e.res = ref_model(f, a, b);
      e.t = $time + lat * 10 + 5;
      sb.push_back(e);
      last_res = e.res;
    end
    #1 start = 0;
  endtask
  task automatic wait_done(input string name);
    bit ok;
    ok = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        chk({name, "_busy_profile"}, {30'b0, ok, busy}, 32'h2);
        return;
      end
      if (!busy) ok = 0;
    end
    chk({name, "_timeout"}, {31'b0, done}, 32'h1);
  endtask
  always @(negedge clk)
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(sb.size()), 32'h1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_time", 32'($time), 32'(e.t));
      end
    end
  logic [2:0] d_f[10] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
  logic [31:0] d_a[10] = '{32'h14, 32'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'h7,
                           32'h8000_0000, 32'h8000_0000, 32'h5, 32'hFFFF_FFF9};
  logic [31:0] d_b[10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h2, 32'h2, 32'h0, 32'h0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
  initial begin
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(d_f[i], d_a[i], d_b[i], 1);
      wait_done("directed");
    end
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 0);
    repeat (10) @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_done", {31'b0, done}, 32'h0);
    chk("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    chk("flush_hold_result", result, last_res);
    issue(3'b101, 32'd100, 32'd7, 1);
    wait_done("after_flush");
    @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3, 1);
    wait_done("b2b_first");
    issue(3'b111, 32'd100, 32'd7, 1);
    wait_done("b2b_second");
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(4, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(f, a, b, 1);
      wait_done("random");
    end
    @(negedge clk);
    issue(3'b100, 32'd12345, 32'd17, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_done", {31'b0, done}, 32'h0);
    chk("async_rst_result", result, 32'h0);
    #1 rst = 0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_result", result, 32'h0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
